// File: rtl/scan_display_ctrl_if.sv
// Bus bundle for scan_display_ctrl: load handshake, shared decoder loop
// (q out, seg_in back) and the multiplexed display drive (an, seg_out).
interface scan_display_ctrl_if;
    logic        load;
    logic [15:0] bcd_in;
    logic        ready;
    logic [3:0]  q;
    logic [6:0]  seg_in;
    logic [3:0]  an;
    logic [6:0]  seg_out;

    // Host / decoder side
    modport master (
        output load, bcd_in, seg_in,
        input  ready, q, an, seg_out
    );

    // Controller side
    modport slave (
        input  load, bcd_in, seg_in,
        output ready, q, an, seg_out
    );
endinterface

// File: rtl/scan_display_ctrl.sv
// Four-digit multiplexed 7-segment scan controller. One external decoder
// is time-shared: each digit slot presents the BCD code on q (SETUP), latches
// the decoder answer into seg_out while enabling the anode (CAPTURE), then
// holds for the rest of the slot. New values are taken through a shadow
// register and only become active at a frame boundary so a frame is never
// torn between two values.
module scan_display_ctrl #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scan_display_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_SETUP   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] cnt_r;
    logic [1:0]  digit_r;
    logic [15:0] active_r;
    logic [15:0] shadow_r;
    logic        ready_r;
    logic [3:0]  q_r;
    logic [3:0]  an_r;
    logic [6:0]  seg_r;

    logic        accept_s;
    logic        wrap_s;
    logic        xfer_s;
    logic [1:0]  next_digit_s;
    logic [15:0] frame_src_s;
    logic [3:0]  digit_val_s;
    logic        blank_s;
    logic [3:0]  q_nxt_s;
    logic [3:0]  an_nxt_s;
    logic [6:0]  seg_nxt_s;

    // Digit k is a leading zero when it and every more significant digit
    // are zero; digit 0 always shows. Non-BCD codes count as non-zero.
    function automatic logic lz_blank(input logic [15:0] val, input logic [1:0] k);
        logic blank;
        blank = (k != 2'd0);
        for (int i = 0; i < 4; i++) begin
            blank = blank & ~((i >= int'(k)) & (val[i*4 +: 4] != 4'd0));
        end
        return blank;
    endfunction

    // Segment pattern for one digit: dash for non-BCD, blank for leading
    // zeros, otherwise whatever the shared decoder returned.
    function automatic logic [6:0] digit_pattern(input logic [3:0] val,
                                                 input logic       blank,
                                                 input logic [6:0] dec);
        logic [6:0] pat;
        if (val > 4'd9) begin
            pat = 7'b0000001;
        end else if (blank) begin
            pat = 7'b0000000;
        end else begin
            pat = dec;
        end
        return pat;
    endfunction

    assign accept_s     = bus.load & ready_r;
    assign wrap_s       = (state_r == ST_HOLD) && (cnt_r == SLOT_LAST);
    assign next_digit_s = digit_r + 2'd1;
    // A pending shadow moves to active only when digit 3 hands over to digit 0
    assign xfer_s       = wrap_s && (digit_r == 2'd3) && !ready_r;
    assign frame_src_s  = xfer_s ? shadow_r : active_r;
    assign digit_val_s  = active_r[{digit_r, 2'b00} +: 4];
    assign blank_s      = (LZ_BLANK == 1'b1) && lz_blank(active_r, digit_r);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_SETUP;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: one SETUP cycle, one CAPTURE cycle, HOLD to slot end
    always_comb begin
        state_nxt_s = ST_SETUP;
        case (state_r)
            ST_SETUP:   state_nxt_s = ST_CAPTURE;
            ST_CAPTURE: state_nxt_s = ST_HOLD;
            ST_HOLD: begin
                if (wrap_s) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default:    state_nxt_s = ST_SETUP;
        endcase
    end

    // FSM outputs: next values for the registered display drive
    always_comb begin
        q_nxt_s   = q_r;
        an_nxt_s  = an_r;
        seg_nxt_s = seg_r;
        case (state_r)
            ST_SETUP: begin
                an_nxt_s  = 4'b0001 << digit_r;
                seg_nxt_s = digit_pattern(digit_val_s, blank_s, bus.seg_in);
            end
            ST_CAPTURE: begin
                an_nxt_s  = an_r;
            end
            ST_HOLD: begin
                if (wrap_s) begin
                    // Anodes off before the next code reaches the decoder
                    an_nxt_s = 4'b0000;
                    q_nxt_s  = frame_src_s[{next_digit_s, 2'b00} +: 4];
                end else begin
                    an_nxt_s = an_r;
                end
            end
            default: begin
                an_nxt_s = 4'b0000;
            end
        endcase
    end

    // Slot timing, digit index, load handshake and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= 16'd0;
            digit_r  <= 2'd0;
            active_r <= 16'h0000;
            shadow_r <= 16'h0000;
            ready_r  <= 1'b1;
            q_r      <= 4'd0;
            an_r     <= 4'b0000;
            seg_r    <= 7'b0000000;
        end else begin
            if (wrap_s) begin
                cnt_r   <= 16'd0;
                digit_r <= next_digit_s;
            end else begin
                cnt_r   <= cnt_r + 16'd1;
            end
            if (accept_s) begin
                shadow_r <= bus.bcd_in;
            end
            if (xfer_s) begin
                active_r <= shadow_r;
            end
            // accept needs ready=1 and transfer needs ready=0, so never both
            if (accept_s) begin
                ready_r <= 1'b0;
            end else if (xfer_s) begin
                ready_r <= 1'b1;
            end
            q_r   <= q_nxt_s;
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
        end
    end

    assign bus.ready   = ready_r;
    assign bus.q       = q_r;
    assign bus.an      = an_r;
    assign bus.seg_out = seg_r;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Bench for scan_display_ctrl: two instances (blanking on / off) with
// SCAN_DIV=4, a conforming decoder model, directed scenarios then random
// loads, every cycle compared against a frame-position reference model.
module tb_scan_display_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] bcd = 16'h0000;
    logic        force_x = 1'b0;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          c;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    logic        m_ready;
    logic [6:0]  m_seg_a;
    logic [6:0]  m_seg_b;

    always #5 clk = ~clk;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b1010101;
        endcase
    endfunction

    scan_display_ctrl_if ifa ();
    scan_display_ctrl_if ifb ();

    assign ifa.load   = load;
    assign ifa.bcd_in = bcd;
    assign ifa.seg_in = force_x ? 7'bxxxxxxx : dec7(ifa.q);
    assign ifb.load   = load;
    assign ifb.bcd_in = bcd;
    assign ifb.seg_in = force_x ? 7'bxxxxxxx : dec7(ifb.q);

    scan_display_ctrl #(.SCAN_DIV(DIV), .LZ_BLANK(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    scan_display_ctrl #(.SCAN_DIV(DIV), .LZ_BLANK(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    // what a digit should look like, from the display rules
    function automatic logic [6:0] expect_pattern(input logic [15:0] act, input int k, input bit lz);
        logic [15:0] upper;
        logic [3:0]  nib;
        upper = act >> (4 * k);
        nib   = upper[3:0];
        if (nib > 4'd9) return 7'b0000001;
        if (lz && (k != 0) && (upper == 16'h0000)) return 7'b0000000;
        return dec7(nib);
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, c);
        end
    endtask

    task automatic check_all();
        int p, dg, sl;
        logic [15:0] exp_an, exp_q;
        p  = c % FRAME;
        dg = p / DIV;
        sl = p % DIV;
        exp_an = (sl == 0) ? 16'h0000 : (16'h0001 << dg);
        exp_q  = (m_active >> (4 * dg)) & 16'h000F;
        chk("an_a",    {12'h000, ifa.an},      exp_an);
        chk("seg_a",   {9'h000, ifa.seg_out},  {9'h000, m_seg_a});
        chk("q_a",     {12'h000, ifa.q},       exp_q);
        chk("ready_a", {15'h0000, ifa.ready},  {15'h0000, m_ready});
        chk("an_b",    {12'h000, ifb.an},      exp_an);
        chk("seg_b",   {9'h000, ifb.seg_out},  {9'h000, m_seg_b});
        chk("q_b",     {12'h000, ifb.q},       exp_q);
        chk("ready_b", {15'h0000, ifb.ready},  {15'h0000, m_ready});
    endtask

    task automatic model_reset();
        c        = 0;
        m_active = 16'h0000;
        m_shadow = 16'h0000;
        m_ready  = 1'b1;
        m_seg_a  = 7'b0000000;
        m_seg_b  = 7'b0000000;
        force_x  = 1'b0;
    endtask

    // advance model across the coming edge, take the edge, then compare
    task automatic cyc();
        int  np, nsl, ndg;
        bit  acc, xf;
        if (rst_n) begin
            np  = (c + 1) % FRAME;
            nsl = np % DIV;
            ndg = np / DIV;
            acc = load && m_ready;
            xf  = (np == 0) && !m_ready;
            if (acc) m_shadow = bcd;
            if (xf)  m_active = m_shadow;
            if (acc)     m_ready = 1'b0;
            else if (xf) m_ready = 1'b1;
            if (nsl == 1) begin
                m_seg_a = expect_pattern(m_active, ndg, 1'b1);
                m_seg_b = expect_pattern(m_active, ndg, 1'b0);
            end
            c = c + 1;
        end
        @(posedge clk);
        #1;
        // garbage on the decoder while a non-BCD digit 1 is being scanned
        force_x = (m_active[7:4] > 4'd9) && (((c % FRAME) / DIV) == 1);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        bcd  = v;
        cyc();
        load = 1'b0;
    endtask

    task automatic run_to(input int dg, input int sl);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((c % FRAME) == (dg * DIV + sl)) break;
            cyc();
        end
    endtask

    // reset asserted between edges: outputs must clear immediately
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cyc();
        cyc();
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        model_reset();
        #2;
        @(posedge clk);
        #1;
        do_reset();

        // idle display: single 0 on digit 0
        idle(2 * FRAME);

        do_load(16'h1234);
        idle(2 * FRAME);

        do_load(16'h0050);
        idle(2 * FRAME);

        do_load(16'h00A7);
        idle(2 * FRAME);

        // second load while busy is dropped
        do_load(16'h1111);
        do_load(16'h2222);
        idle(2 * FRAME);
        do_load(16'h2222);
        idle(2 * FRAME);

        // reset mid-hold of digit 2 with 9999 still pending
        run_to(0, 1);
        do_load(16'h9999);
        run_to(2, 2);
        do_reset();
        idle(2 * FRAME);

        // random loads, including non-BCD nibbles
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 3) == 0);
            bcd  = 16'($urandom);
            cyc();
        end
        load = 1'b0;
        idle(2 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_display_ctrl.md
SCAN_DISPLAY_CTRL -- requirements
Module: scan_display_ctrl

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 1000, clock cycles each digit occupies per scan slot (legal range 4..65535).
REQ-002 SHALL provide parameter LZ_BLANK, default 1, 1 = leading-zero blanking enabled, 0 = all four digits always shown.
REQ-003 clk  input  1  single clock, all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  request to update displayed value; accepted only when ready=1.
REQ-006 bcd_in  input  16  four BCD digits; [3:0] digit 0 (least significant) ... [15:12] digit 3.
REQ-007 ready  output  1  high when a new load can be accepted.
REQ-008 q  output  4  BCD code driven to the shared 7-segment decoder.
REQ-009 seg_in  input  7  decoder result for q, order {a,b,c,d,e,f,g}, active-high.
REQ-010 an  output  4  one-hot digit enable, active-high, an[k] = digit k.
REQ-011 seg_out  output  7  registered segment pattern for the enabled digit, active-high.

Function
REQ-012 SHALL time-share one combinational decoder across four digits, scanning digit 0,1,2,3,0,... ; frame = 4*SCAN_DIV cycles.
REQ-013 Per-digit FSM SHALL be SETUP -> CAPTURE -> HOLD -> SETUP(next digit).
REQ-014 SETUP (1 cycle): q = active digit k value; an = 4'b0000 (ghosting guard); seg_out holds its previous value.
REQ-015 CAPTURE (1 cycle): seg_out registered from seg_in (or override, REQ-018/019); an[k] set one-hot at the same edge.
REQ-016 HOLD: an and seg_out stable for SCAN_DIV-2 cycles; slot counter then wraps to 0, digit index increments mod 4 (3 -> 0).
REQ-017 q SHALL remain stable from SETUP through end of HOLD for the same digit.
REQ-018 Digit value >9: seg_out SHALL be 7'b0000001 (dash, segment g) regardless of seg_in.
REQ-019 LZ_BLANK=1: digit k (k=3..1) blanked (seg_out = 7'b0000000, an[k] still asserted) when digit k and every higher digit are 0; digit 0 never blanked; a >9 digit counts as non-zero.
REQ-020 Load handshake: load=1 while ready=1 SHALL copy bcd_in into a shadow register on that edge and drop ready the next cycle.
REQ-021 load while ready=0 SHALL be ignored (no shadow update, no error).
REQ-022 Shadow SHALL transfer to the active register on the edge entering SETUP of digit 0 (frame boundary); ready returns to 1 on that same edge.
REQ-023 Load accepted on the same edge as a frame-boundary transfer SHALL NOT affect the current transfer; it transfers at the next frame boundary.
REQ-024 Active register SHALL never change mid-frame; blanking decisions use the active register only.

Reset
REQ-025 rst_n low SHALL immediately force: an=0, seg_out=0, q=0, ready=1, shadow=0, active=0, digit index=0, slot counter=0, FSM=SETUP.
REQ-026 After rst_n deasserts, first rising edge SHALL begin SETUP of digit 0; with active=0 and LZ_BLANK=1 the display shows a single "0" on digit 0 (seg_out=7'b1111110 with a conforming decoder).
REQ-027 Reset asserted mid-load or mid-frame SHALL discard the pending shadow and restart per REQ-025/026.

Verification
REQ-028 Reset then idle, SCAN_DIV=4, conforming decoder: digit 0 shows 7'b1111110, digits 1-3 seg_out=0, an sequence 0001,0010,0100,1000 each asserted 3 of 4 cycles, an=0 during SETUP.
REQ-029 load bcd_in=16'h1234 at ready=1: ready low until next frame boundary; following frame seg_out = 0110011,1111001,1101101,0110000 for digits 0..3.
REQ-030 load 16'h0050 with LZ_BLANK=1: digit 3 and 2 blank, digit 1 = 1011011, digit 0 = 1111110; repeat with LZ_BLANK=0: digits 3,2 = 1111110.
REQ-031 load 16'h00A7: digit 1 = 7'b0000001, digit 0 = 1110000, digits 3,2 blank; seg_in forced to X during digit-1 slot does not propagate.
REQ-032 Second load pulsed while ready=0 (values 16'h1111 then 16'h2222): only 16'h1111 displayed; 16'h2222 accepted only after ready rises.
REQ-033 rst_n pulsed low mid-HOLD of digit 2 after load 16'h9999 pending: outputs zero at once, ready=1, display restarts as REQ-026, 16'h9999 never shown.
